// File: rtl/fpu_exc_sched_pkg.sv
// mypkg -- opcode and FSM state types plus IEEE-754 flag bit indices
// shared by the FPU exception scheduler (rev 1.0).
`default_nettype none

package mypkg;

  typedef enum logic [2:0] {
    OP_ADD    = 3'd0,
    OP_SUB    = 3'd1,
    OP_MUL    = 3'd2,
    OP_DIV    = 3'd3,
    OP_FMADD  = 3'd4,
    OP_SQRT   = 3'd5,
    OP_MINMAX = 3'd6,
    OP_CVT    = 3'd7
  } fpu_op_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  localparam int unsigned FLG_NV = 4;
  localparam int unsigned FLG_DZ = 3;
  localparam int unsigned FLG_OF = 2;
  localparam int unsigned FLG_UF = 1;
  localparam int unsigned FLG_NX = 0;

  // Classifiers take exponent+mantissa only; the sign is handled by callers.
  function automatic logic is_zero(input logic [30:0] m);
    return m == 31'd0;
  endfunction

  function automatic logic is_inf(input logic [30:0] m);
    return (m[30:23] == 8'hFF) && (m[22:0] == 23'd0);
  endfunction

  function automatic logic is_nan(input logic [30:0] m);
    return (m[30:23] == 8'hFF) && (m[22:0] != 23'd0);
  endfunction

  function automatic logic is_snan(input logic [30:0] m);
    return is_nan(m) && !m[22];
  endfunction

endpackage

`default_nettype wire

// File: rtl/fpu_exc_sched_exc.sv
// fpu_exc_sched_exc -- exception-flag evaluator with an EXC_LAT-deep flag
// pipeline; the shared resource arbitrated by fpu_exc_sched (rev 1.0).
`default_nettype none

module fpu_exc_sched_exc
  import mypkg::*;
#(
  parameter int unsigned EXC_LAT = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        valid_i,
  input  fpu_op_e     op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] c_i,
  input  logic [31:0] fab_i,
  output logic [4:0]  flags_o
);

  logic [4:0]  flags_d;
  logic [7:0]  ea, eb;
  logic [23:0] ma, mb;
  logic [47:0] prod;
  logic [9:0]  esum;
  logic        sticky, ab_snan, ab_special, mul_nv, ab_finite;
  logic        unused_prod;
  logic [4:0]  pipe_q [EXC_LAT];

  // Denormals use exponent 1 with a zero hidden bit.
  assign ea   = (a_i[30:23] == 8'd0) ? 8'd1 : a_i[30:23];
  assign eb   = (b_i[30:23] == 8'd0) ? 8'd1 : b_i[30:23];
  assign ma   = {a_i[30:23] != 8'd0, a_i[22:0]};
  assign mb   = {b_i[30:23] != 8'd0, b_i[22:0]};
  assign prod = {24'd0, ma} * {24'd0, mb};
  assign esum = {2'b00, ea} + {2'b00, eb} + {9'd0, prod[47]};
  assign sticky      = prod[47] ? (|prod[23:0]) : (|prod[22:0]);
  assign unused_prod = ^prod[46:24];

  assign ab_snan    = is_snan(a_i[30:0]) || is_snan(b_i[30:0]);
  assign mul_nv     = ab_snan || (is_zero(a_i[30:0]) && is_inf(b_i[30:0]))
                              || (is_inf(a_i[30:0]) && is_zero(b_i[30:0]));
  assign ab_finite  = !is_nan(a_i[30:0]) && !is_inf(a_i[30:0])
                   && !is_nan(b_i[30:0]) && !is_inf(b_i[30:0]);
  assign ab_special = !ab_finite || is_zero(a_i[30:0]) || is_zero(b_i[30:0]);

  always_comb begin
    flags_d = '0;
    case (op_i)
      OP_ADD, OP_SUB: begin
        flags_d[FLG_NV] = ab_snan || (is_inf(a_i[30:0]) && is_inf(b_i[30:0])
                          && (a_i[31] != (b_i[31] ^ (op_i == OP_SUB))));
      end
      OP_MUL: begin
        if (mul_nv) begin
          flags_d[FLG_NV] = 1'b1;
        end else if (!ab_special) begin
          // esum carries a +127 bias on top of the biased result exponent.
          if (esum >= 10'd382) begin
            flags_d[FLG_OF] = 1'b1;
            flags_d[FLG_NX] = 1'b1;
          end else if (esum <= 10'd127) begin
            flags_d[FLG_UF] = 1'b1;
            flags_d[FLG_NX] = 1'b1;
          end else begin
            flags_d[FLG_NX] = sticky;
          end
        end
      end
      OP_DIV: begin
        if (ab_snan || (is_zero(a_i[30:0]) && is_zero(b_i[30:0]))
                    || (is_inf(a_i[30:0]) && is_inf(b_i[30:0]))) begin
          flags_d[FLG_NV] = 1'b1;
        end else if (is_zero(b_i[30:0]) && !is_zero(a_i[30:0])
                     && !is_nan(a_i[30:0]) && !is_inf(a_i[30:0])) begin
          flags_d[FLG_DZ] = 1'b1;
        end
      end
      OP_FMADD: begin
        if (mul_nv || is_snan(c_i[30:0]) || (is_inf(fab_i[30:0]) && is_inf(c_i[30:0])
                                             && (fab_i[31] != c_i[31]))) begin
          flags_d[FLG_NV] = 1'b1;
        end else if (is_inf(fab_i[30:0]) && ab_finite) begin
          flags_d[FLG_OF] = 1'b1;
          flags_d[FLG_NX] = 1'b1;
        end
      end
      default: flags_d = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < EXC_LAT; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= valid_i ? flags_d : 5'd0;
      for (int i = 1; i < EXC_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign flags_o = pipe_q[EXC_LAT-1];

endmodule

`default_nettype wire

// File: rtl/fpu_exc_sched.sv
// fpu_exc_sched -- two-requester round-robin scheduler for the shared FPU
// exception evaluator, with sticky fflags accumulation (rev 1.0).
`default_nettype none

module fpu_exc_sched
  import mypkg::*;
#(
  parameter int unsigned EXC_LAT = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [1:0]       req_valid_i,
  output logic [1:0]       req_ready_o,
  input  logic [1:0][31:0] req_a_i,
  input  logic [1:0][31:0] req_b_i,
  input  logic [1:0][31:0] req_c_i,
  input  logic [1:0][31:0] req_fab_i,
  input  fpu_op_e [1:0]    req_op_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic             rsp_id_o,
  output logic [4:0]       rsp_flags_o,
  output logic [4:0]       fflags_o,
  input  logic             fflags_clr_i,
  input  logic             fflags_we_i,
  input  logic [4:0]       fflags_wdata_i,
  output logic             busy_o
);

  localparam logic [1:0] CNT_INIT = 2'(EXC_LAT - 1);

  state_e      state_q, state_d;
  fpu_op_e     op_q;
  logic [31:0] a_q, b_q, c_q, fab_q;
  logic [1:0]  cnt_q, cnt_d, grant;
  logic [4:0]  rsp_flags_q, rsp_flags_d, fflags_q, fflags_d, exc_flags;
  logic        prio_q, id_q, sel, accept, launch, rsp_hs;

  // prio_q names the requester that wins a tie.
  assign sel = (req_valid_i == 2'b11) ? prio_q : req_valid_i[1];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_flags_d = rsp_flags_q;
    grant       = 2'b00;
    accept      = 1'b0;
    launch      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|req_valid_i) begin
          accept  = 1'b1;
          grant   = sel ? 2'b10 : 2'b01;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        launch  = 1'b1;
        cnt_d   = CNT_INIT;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == 2'd0) begin
          rsp_flags_d = exc_flags;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Software write/clear applies first so a coincident response is never lost.
  assign rsp_hs   = (state_q == S_RESP) && rsp_ready_i;
  assign fflags_d = (fflags_clr_i ? 5'd0 : (fflags_we_i ? fflags_wdata_i : fflags_q))
                  | (rsp_hs ? rsp_flags_q : 5'd0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      cnt_q       <= 2'd0;
      rsp_flags_q <= 5'd0;
      fflags_q    <= 5'd0;
      prio_q      <= 1'b0;
      id_q        <= 1'b0;
      op_q        <= OP_ADD;
      a_q         <= 32'd0;
      b_q         <= 32'd0;
      c_q         <= 32'd0;
      fab_q       <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_flags_q <= rsp_flags_d;
      fflags_q    <= fflags_d;
      if (accept) begin
        prio_q <= ~sel;
        id_q   <= sel;
        op_q   <= req_op_i[sel];
        a_q    <= req_a_i[sel];
        b_q    <= req_b_i[sel];
        c_q    <= req_c_i[sel];
        fab_q  <= req_fab_i[sel];
      end
    end
  end

  fpu_exc_sched_exc #(
    .EXC_LAT (EXC_LAT)
  ) u_exc (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (launch),
    .op_i    (op_q),
    .a_i     (a_q),
    .b_i     (b_q),
    .c_i     (c_q),
    .fab_i   (fab_q),
    .flags_o (exc_flags)
  );

  // Gating with rst_ni keeps the grant low while reset is held in IDLE.
  assign req_ready_o = grant & {2{rst_ni}};
  assign rsp_valid_o = (state_q == S_RESP);
  assign rsp_id_o    = id_q;
  assign rsp_flags_o = rsp_flags_q;
  assign fflags_o    = fflags_q;
  assign busy_o      = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_fpu_exc_sched.sv
// tb_fpu_exc_sched -- directed self-checking bench for fpu_exc_sched.
`default_nettype none

module tb_fpu_exc_sched;
  import mypkg::*;

  localparam int EXC_LAT = 1;

  logic             clk = 1'b0;
  logic             rst_ni;
  logic [1:0]       req_valid, req_ready;
  logic [1:0][31:0] req_a, req_b, req_c, req_fab;
  fpu_op_e [1:0]    req_op;
  logic             rsp_valid, rsp_ready, rsp_id;
  logic [4:0]       rsp_flags, fflags, fflags_wdata;
  logic             fflags_clr, fflags_we, busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fpu_exc_sched #(.EXC_LAT(EXC_LAT)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_a_i        (req_a),
    .req_b_i        (req_b),
    .req_c_i        (req_c),
    .req_fab_i      (req_fab),
    .req_op_i       (req_op),
    .rsp_valid_o    (rsp_valid),
    .rsp_ready_i    (rsp_ready),
    .rsp_id_o       (rsp_id),
    .rsp_flags_o    (rsp_flags),
    .fflags_o       (fflags),
    .fflags_clr_i   (fflags_clr),
    .fflags_we_i    (fflags_we),
    .fflags_wdata_i (fflags_wdata),
    .busy_o         (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Issues one request, then returns at the negedge where rsp_valid is seen.
  task automatic run_op(input int rid, input logic [31:0] a, input logic [31:0] b,
                        input fpu_op_e op, input logic [4:0] exp_flags, input string tag);
    int lat;
    @(negedge clk);
    req_a[rid] = a; req_b[rid] = b; req_c[rid] = '0; req_fab[rid] = '0;
    req_op[rid] = op; req_valid[rid] = 1'b1;
    #1 check({tag, "_ready"}, 32'(req_ready), 32'(2'b01 << rid));
    @(negedge clk);
    req_valid[rid] = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(EXC_LAT + 2));
    check({tag, "_id"}, 32'(rsp_id), 32'(rid));
    check({tag, "_flags"}, 32'(rsp_flags), 32'(exp_flags));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, cnt, g_n, r_n;
    int g_id [8];
    int r_id [8];
    int r_fl [8];

    rst_ni = 1'b0; req_valid = 2'b11; rsp_ready = 1'b1;
    req_a = '0; req_b = '0; req_c = '0; req_fab = '0; req_op = {OP_ADD, OP_ADD};
    fflags_clr = 1'b0; fflags_we = 1'b0; fflags_wdata = '0;
    #12;
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_outs", 32'({rsp_valid, busy, rsp_id, rsp_flags, fflags}), 32'd0);
    req_valid = 2'b00;
    @(negedge clk);
    rst_ni = 1'b1;

    // MUL overflow from requester 0
    run_op(0, 32'h7F7FFFFF, 32'h7F7FFFFF, OP_MUL, 5'b00101, "mul_of");
    @(negedge clk);
    check("mul_of_fflags", 32'(fflags), 32'h05);
    check("mul_of_done", 32'({rsp_valid, busy}), 32'd0);

    // Divide by zero with clear in the handshake cycle
    run_op(0, 32'h3F800000, 32'h00000000, OP_DIV, 5'b01000, "div_dz");
    fflags_clr = 1'b1;
    @(negedge clk);
    fflags_clr = 1'b0;
    check("div_dz_fflags", 32'(fflags), 32'h08);

    // Invalid 0*inf with write in the handshake cycle
    run_op(1, 32'h00000000, 32'h7F800000, OP_MUL, 5'b10000, "mul_nv");
    fflags_we = 1'b1; fflags_wdata = 5'b00001;
    @(negedge clk);
    fflags_we = 1'b0;
    check("mul_nv_fflags", 32'(fflags), 32'h11);

    // Backpressure on an inf-inf response while requester 0 waits
    rsp_ready = 1'b0;
    run_op(1, 32'h7F800000, 32'hFF800000, OP_ADD, 5'b10000, "add_nv");
    req_a[0] = 32'h00000000; req_b[0] = 32'h7F800000; req_op[0] = OP_CVT; req_valid[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1 check("bp_hold", 32'({rsp_valid, rsp_id, rsp_flags, req_ready}),
                          32'({1'b1, 1'b1, 5'b10000, 2'b00}));
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1 check("bp_ready_resp", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("bp_one_hs", 32'({rsp_valid, fflags}), 32'h11);
    #1 check("bp_pending_grant", 32'(req_ready), 32'b01);
    @(negedge clk);
    req_valid[0] = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("cvt_lat", 32'(lat), 32'(EXC_LAT + 2));
    check("cvt_flags", 32'({rsp_id, rsp_flags}), 32'd0);
    @(negedge clk);
    check("cvt_fflags", 32'({rsp_valid, fflags}), 32'h11);

    // Reset while the operation sits in WAIT
    req_a[1] = 32'h7F7FFFFF; req_b[1] = 32'h7F7FFFFF; req_op[1] = OP_MUL; req_valid[1] = 1'b1;
    @(negedge clk);
    req_valid[1] = 1'b0;
    @(negedge clk);
    check("wait_busy", 32'({busy, rsp_valid, rsp_id}), 32'b101);
    #2 rst_ni = 1'b0; req_valid = 2'b11;
    #1 check("mid_rst_outs", 32'({rsp_valid, busy, rsp_id, rsp_flags, fflags, req_ready}), 32'd0);
    req_valid = 2'b00;
    @(negedge clk);
    rst_ni = 1'b1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid || busy) cnt++;
    end
    check("post_rst_quiet", 32'(cnt), 32'd0);
    check("post_rst_fflags", 32'(fflags), 32'd0);

    // Contention: both requesters continuously valid
    for (int i = 0; i < 8; i++) begin
      g_id[i] = -1; r_id[i] = -1; r_fl[i] = -1;
    end
    g_n = 0; r_n = 0;
    req_a[0] = 32'h7F7FFFFF; req_b[0] = 32'h7F7FFFFF; req_op[0] = OP_MUL;
    req_a[1] = 32'h3F800000; req_b[1] = 32'h00000000; req_op[1] = OP_DIV;
    req_valid = 2'b11;
    for (int i = 0; i < 16; i++) begin
      #1;
      if (req_ready != 2'b00 && g_n < 8) begin
        g_id[g_n] = int'(req_ready[1]);
        g_n++;
      end
      if (rsp_valid && rsp_ready && r_n < 8) begin
        r_id[r_n] = int'(rsp_id);
        r_fl[r_n] = int'(rsp_flags);
        r_n++;
      end
      @(negedge clk);
    end
    req_valid = 2'b00;
    check("cont_grants", 32'(g_n), 32'd4);
    check("cont_rsps", 32'(r_n), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("cont_gid", 32'(g_id[i]), 32'(i % 2));
      check("cont_rid", 32'(r_id[i]), 32'(i % 2));
      check("cont_rflags", 32'(r_fl[i]), (i % 2 == 0) ? 32'h05 : 32'h08);
    end
    @(negedge clk);
    check("cont_fflags", 32'({busy, fflags}), 32'h0D);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fpu_exc_sched.md
FPU_EXC_SCHED -- requirements
Module: fpu_exc_sched

Interface
REQ-001 SHALL have parameter EXC_LAT, default 1: cycles from operand launch into the exception sub-module to valid flags (1..3).
REQ-002 SHALL have ports clk_i input 1 (single clock) and rst_ni input 1 (asynchronous, active-low reset).
REQ-003 SHALL have req_valid_i input 2: per-requester request valid; bit 0 is requester 0.
REQ-004 SHALL have req_ready_o output 2: per-requester grant/accept, asserted for the accepting cycle only.
REQ-005 SHALL have req_a_i, req_b_i, req_c_i, req_fab_i inputs 2x32 each: per-requester operands and intermediate a*b result.
REQ-006 SHALL have req_op_i input 2x fpu_op_e: per-requester opcode.
REQ-007 SHALL have rsp_valid_o output 1, rsp_ready_i input 1, rsp_id_o output 1 (granted requester), rsp_flags_o output 5 {NV,DZ,OF,UF,NX}.
REQ-008 SHALL have fflags_o output 5 (sticky accumulated flags), fflags_clr_i input 1, fflags_we_i input 1, fflags_wdata_i input 5.
REQ-009 SHALL have busy_o output 1, high in every state except IDLE.

Function
REQ-010 SHALL implement FSM IDLE -> LAUNCH -> WAIT -> RESP -> IDLE, with one operation in flight at most.
REQ-011 IDLE: if any req_valid_i bit is set, SHALL grant one requester by round-robin, pulse its req_ready_o, latch its operands, opcode and id, and go to LAUNCH.
REQ-012 Round-robin SHALL favour the requester not granted last; after reset, requester 0 has priority; a single active requester is granted every time.
REQ-013 LAUNCH SHALL drive the latched operands into the exception sub-module for one cycle, load the latency counter with EXC_LAT-1, and go to WAIT.
REQ-014 WAIT SHALL decrement the counter; at zero it SHALL capture the five sub-module flags into rsp_flags_o and go to RESP.
REQ-015 RESP SHALL hold rsp_valid_o=1 with stable rsp_id_o and rsp_flags_o until rsp_ready_i=1; on that handshake it SHALL return to IDLE.
REQ-016 Grant-to-rsp_valid_o latency SHALL be EXC_LAT+2 cycles; with rsp_ready_i held high, back-to-back grants SHALL be EXC_LAT+3 cycles apart.
REQ-017 req_ready_o SHALL be 0 outside IDLE; requests arriving while busy SHALL wait, and requesters SHALL keep req_valid_i and payload stable until ready.
REQ-018 On each response handshake, fflags SHALL be updated to fflags | rsp_flags_o.
REQ-019 fflags_we_i SHALL load fflags_wdata_i; fflags_clr_i SHALL zero fflags; if both are asserted, clear wins.
REQ-020 If a write or clear coincides with a response handshake, the write/clear value SHALL be applied first and rsp_flags_o ORed in, so no exception is lost.
REQ-021 fflags_o SHALL reflect the register with no combinational path from rsp_ready_i.
REQ-022 An opcode not handled by the sub-module SHALL still complete with rsp_flags_o = 5'b00000.

Reset
REQ-023 Asserting rst_ni=0 SHALL immediately force state IDLE, req_ready_o=0, rsp_valid_o=0, rsp_id_o=0, rsp_flags_o=0, fflags_o=0, busy_o=0, and round-robin pointer to requester 0.
REQ-024 Reset mid-operation SHALL abandon the in-flight operation with no response and no fflags update.
REQ-025 Reset deassertion SHALL be synchronised by the reset owner; the block SHALL accept new requests from the first clock edge after deassertion.

Structure
REQ-026 fpu_op_e, the flag-index constants (NV=4, DZ=3, OF=2, UF=1, NX=0) and the FSM state enum SHALL live in mypkg.
REQ-027 The block SHALL instantiate exactly one exception sub-module, sharing clk_i, as the scheduled resource.
REQ-028 The block SHALL contain the FSM, round-robin pointer, operand/id latches, latency counter and fflags register, with no other sub-modules.

Verification
REQ-029 Single request: requester 0, a=0x7F7FFFFF, b=0x7F7FFFFF, op=MUL -> rsp_valid_o 3 cycles after grant (EXC_LAT=1), rsp_id_o=0, OF=1, NX=1, fflags_o=5'b00101.
REQ-030 Contention: both requesters valid continuously, rsp_ready_i=1 -> grants alternate 0,1,0,1, four responses in 16 cycles.
REQ-031 Backpressure: rsp_ready_i=0 for 5 cycles in RESP -> rsp_valid_o, rsp_id_o and flags stable, req_ready_o=0 throughout, then exactly one handshake.
REQ-032 Divide by zero: a=0x3F800000, b=0x00000000, op=DIV -> DZ=1; fflags_clr_i in the handshake cycle -> fflags_o=5'b01000 (DZ bit 3).
REQ-033 Invalid: a=0x00000000, b=0x7F800000, op=MUL -> NV=1; fflags_we_i with wdata=5'b00001 in the same cycle -> fflags_o=5'b10001.
REQ-034 Reset during WAIT -> all outputs 0 asynchronously, no response afterwards; the next request is granted to requester 0.
